irrigation_scheduler: RTL

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

---
 rtl/irrigation_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
//   Two-area irrigation sequencer sharing a single pump. A dry-soil request
//   is granted round-robin; the granted valve opens, settles, the pump runs,
//   then the valve settles closed before returning to idle.
//
//   Optional feature: define IRRIG_FAULT_DETECT_EN to compile in per-area
//   dry-fault detection (an area still dry after three consecutive waterings
//   is flagged and masked from arbitration until reset).
//
// Parameters
//   WATER_CYCLES   pump-on cycles per watering          (1..255)
//   SETTLE_CYCLES  valve open/close settle cycles       (1..15)
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   U      in   2  dry-soil request per area
//   valve  out  2  valve enables, one-hot or zero
//   pump   out  1  shared pump enable
//   busy   out  1  high whenever not idle
//   done   out  1  one-cycle pulse on the first idle cycle after a watering
//   fault  out  2  per-area dry-fault flags (tied low without the macro)

module irrigation_scheduler #(
    parameter int unsigned WATER_CYCLES  = 8,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] U,
    output logic [1:0] valve,
    output logic       pump,
    output logic       busy,
    output logic       done,
    output logic [1:0] fault
);

    typedef enum logic [1:0] {IDLE, OPEN, PUMP, CLOSE} state_t;

    // Phase counter counts down from (length-1) loaded on entry; 0 ends the phase.
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] WATER_LD  = 8'(WATER_CYCLES - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       area, area_n;     // granted area index
    logic       last, last_n;     // last-served area
    logic       done_q, done_n;
    logic [1:0] elig;
    logic       close_done;

    assign close_done = (state == CLOSE) && (cnt == '0);

`ifdef IRRIG_FAULT_DETECT_EN
    logic [1:0][1:0] fcnt;
    logic [1:0]      fault_q;

    assign elig  = U & ~fault_q;
    assign fault = fault_q;

    // Counters saturate at 3; the flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt    <= '0;
            fault_q <= '0;
        end else if (close_done) begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (U[i]) begin
                    if (fcnt[i] != 2'd3) fcnt[i] <= fcnt[i] + 2'd1;
                    if (fcnt[i] >= 2'd2) fault_q[i] <= 1'b1;
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end
`else
    assign elig  = U;
    assign fault = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            area   <= 1'b0;
            last   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            area   <= area_n;
            last   <= last_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        area_n  = area;
        last_n  = last;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (elig != '0) begin
                    state_n = OPEN;
                    cnt_n   = SETTLE_LD;
                    // On a tie serve the area that was not served last.
                    area_n  = (elig == 2'b11) ? ~last : elig[1];
                end
            end
            OPEN: begin
                if (cnt == '0) begin
                    state_n = PUMP;
                    cnt_n   = WATER_LD;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            PUMP: begin
                if (cnt == '0) begin
                    state_n = CLOSE;
                    cnt_n   = SETTLE_LD;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            CLOSE: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    last_n  = area;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign valve = (state != IDLE) ? (area ? 2'b10 : 2'b01) : 2'b00;
    assign pump  = (state == PUMP);
    assign busy  = (state != IDLE);
    assign done  = done_q;

endmodule
